msk_key_bank: RTL and testbench

MSK_KEY_BANK -- requirements
Module: msk_key_bank

---
 rtl/msk_key_bank.sv | 252 +++++++++++++++++++++++++
 tb/tb_msk_key_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_key_bank.sv
// msk_key_bank: bank of masked (d-share) key slots feeding a masked AES core.
//
// Keys are loaded share by share over a narrow bus, one slot is selected as
// the active slot and presented on the sharing bus, and every start of an
// AES execution triggers a refresh of the active slot with fresh randomness.
// The unshared key (XOR of all shares) is never changed by a refresh.
//
// Optional feature: define MSK_KEY_BANK_ZEROIZE_EN to add the zeroize input
// and the ZEROIZE state, which wipes all slots in a single cycle.
//
// Ports:
//   clk                 clock
//   rst                 asynchronous reset, active-low
//   data_in             load word (one DIN_W-bit piece of one share)
//   data_in_valid       load word valid
//   data_in_ready       load word accepted when valid & ready (LOAD state)
//   start_load          request to load load_slot with a key of key_size_cfg
//   load_slot           target slot, sampled with start_load
//   key_size_cfg        0=128, 1=192, 2=256 bits, sampled with start_load
//   sel_slot            new active slot, sampled with sel_valid
//   sel_valid           change the active slot
//   zeroize             wipe all slots (only with MSK_KEY_BANK_ZEROIZE_EN)
//   aes_busy            core busy; its rising edge marks an execution start
//   rnd_rfrsh_in        refresh randomness, (d-1) chunks of RFRSH_RATE bits
//   rnd_rfrsh_in_valid  randomness valid; one refresh step per valid cycle
//   sh_data_out         active slot, bit j of share i at index j*d+i
//   aes_mode_256        active slot holds a 256-bit key
//   aes_mode_192        active slot holds a 192-bit key
//   busy                FSM not IDLE, or a refresh is pending
module msk_key_bank #(
    parameter int d          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16,
    parameter int SLOTS      = 2,
    parameter int DIN_W      = 32,
    localparam int SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIN_W-1:0]             data_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    input  logic                         start_load,
    input  logic [SW-1:0]                load_slot,
    input  logic [1:0]                   key_size_cfg,
    input  logic [SW-1:0]                sel_slot,
    input  logic                         sel_valid,
`ifdef MSK_KEY_BANK_ZEROIZE_EN
    input  logic                         zeroize,
`endif
    input  logic                         aes_busy,
    input  logic [(d-1)*RFRSH_RATE-1:0]  rnd_rfrsh_in,
    input  logic                         rnd_rfrsh_in_valid,
    output logic [d*BITS-1:0]            sh_data_out,
    output logic                         aes_mode_256,
    output logic                         aes_mode_192,
    output logic                         busy
);

    localparam int WORDS = BITS / DIN_W;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int STEPS = BITS / RFRSH_RATE;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DW    = (d > 1) ? $clog2(d) : 1;

`ifdef MSK_KEY_BANK_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE, LOAD, REFRESH, ZEROIZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, REFRESH} state_t;
`endif

    // Key width in bits for a stored size code; unknown codes behave as 128,
    // consistent with both mode outputs being low for them.
    function automatic int key_bits(input logic [1:0] sz);
        int b;
        case (sz)
            2'd2:    b = 256;
            2'd1:    b = 192;
            default: b = 128;
        endcase
        return (b > BITS) ? BITS : b;
    endfunction

    state_t                   state, state_next;
    logic [d-1:0][BITS-1:0]   key_mem   [SLOTS];
    logic [1:0]               slot_size [SLOTS];
    logic [SW-1:0]            act_slot, tgt_slot;
    logic [DW-1:0]            sh_cnt;
    logic [WW-1:0]            wd_cnt;
    logic [KW-1:0]            step_cnt;
    logic                     pending, busy_prev, armed;
    logic                     rise, load_accept, beat_accept, step_accept;
    logic                     refresh_enter, clear_all, last_word, last_beat, last_step;
    int                       load_words, ref_steps;
    logic [RFRSH_RATE-1:0]    rnd_fold;

    // armed stays low for the first clock after reset so that aes_busy
    // already being high at release is not mistaken for an execution start.
    always_comb begin
        rise       = aes_busy & ~busy_prev & armed;
        load_words = key_bits(slot_size[tgt_slot]) / DIN_W;
        ref_steps  = key_bits(slot_size[act_slot]) / RFRSH_RATE;
        last_word  = (int'(wd_cnt) == load_words - 1);
        last_beat  = last_word && (int'(sh_cnt) == d - 1);
        last_step  = (int'(step_cnt) == ref_steps - 1);
    end

    // Share 0 absorbs the XOR of all random chunks so the unshared value
    // is unchanged by a refresh step.
    always_comb begin
        rnd_fold = '0;
        for (int i = 1; i < d; i++) begin
            rnd_fold = rnd_fold ^ rnd_rfrsh_in[(i-1)*RFRSH_RATE +: RFRSH_RATE];
        end
    end

    always_comb begin
        state_next    = state;
        load_accept   = 1'b0;
        beat_accept   = 1'b0;
        step_accept   = 1'b0;
        refresh_enter = 1'b0;
        clear_all     = 1'b0;
        case (state)
            IDLE: begin
`ifdef MSK_KEY_BANK_ZEROIZE_EN
                if (zeroize) begin
                    state_next = ZEROIZE;
                    clear_all  = 1'b1;
                end else
`endif
                if (rise || pending) begin
                    state_next    = REFRESH;
                    refresh_enter = 1'b1;
                end else if (start_load) begin
                    state_next  = LOAD;
                    load_accept = 1'b1;
                end
            end
            LOAD: begin
                if (data_in_valid) begin
                    beat_accept = 1'b1;
                    if (last_beat) state_next = IDLE;
                end
            end
            REFRESH: begin
                if (rnd_rfrsh_in_valid) begin
                    step_accept = 1'b1;
                    if (last_step) state_next = IDLE;
                end
            end
`ifdef MSK_KEY_BANK_ZEROIZE_EN
            ZEROIZE: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            busy_prev <= 1'b0;
            armed     <= 1'b0;
            act_slot  <= '0;
            tgt_slot  <= '0;
            sh_cnt    <= '0;
            wd_cnt    <= '0;
            step_cnt  <= '0;
        end else begin
            state     <= state_next;
            busy_prev <= aes_busy;
            armed     <= 1'b1;
            // An execution start seen outside IDLE is remembered and served
            // as soon as IDLE is reached; zeroize discards it.
            if (clear_all || refresh_enter) begin
                pending <= 1'b0;
            end else if (rise && (state != IDLE)) begin
                pending <= 1'b1;
            end
            if ((state == IDLE) && !pending && sel_valid) begin
                act_slot <= sel_slot;
            end
            if (load_accept) begin
                tgt_slot <= load_slot;
                sh_cnt   <= '0;
                wd_cnt   <= '0;
            end else if (beat_accept) begin
                if (last_word) begin
                    wd_cnt <= '0;
                    sh_cnt <= sh_cnt + 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
            if (refresh_enter) begin
                step_cnt <= '0;
            end else if (step_accept) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SLOTS; s++) begin
                key_mem[s]   <= '0;
                slot_size[s] <= 2'd0;
            end
        end else if (clear_all) begin
            for (int s = 0; s < SLOTS; s++) begin
                key_mem[s]   <= '0;
                slot_size[s] <= 2'd0;
            end
        end else begin
            // Clearing on accept guarantees unused upper bits of a shorter
            // key are zero.
            if (load_accept) begin
                key_mem[load_slot]   <= '0;
                slot_size[load_slot] <= key_size_cfg;
            end
            if (beat_accept) begin
                key_mem[tgt_slot][sh_cnt][int'(wd_cnt)*DIN_W +: DIN_W] <= data_in;
            end
            if (step_accept) begin
                for (int i = 1; i < d; i++) begin
                    key_mem[act_slot][i][int'(step_cnt)*RFRSH_RATE +: RFRSH_RATE] <=
                        key_mem[act_slot][i][int'(step_cnt)*RFRSH_RATE +: RFRSH_RATE] ^
                        rnd_rfrsh_in[(i-1)*RFRSH_RATE +: RFRSH_RATE];
                end
                key_mem[act_slot][0][int'(step_cnt)*RFRSH_RATE +: RFRSH_RATE] <=
                    key_mem[act_slot][0][int'(step_cnt)*RFRSH_RATE +: RFRSH_RATE] ^ rnd_fold;
            end
        end
    end

    // Sharing-bus layout: all shares of key bit j are adjacent.
    always_comb begin
        sh_data_out = '0;
        for (int j = 0; j < BITS; j++) begin
            for (int i = 0; i < d; i++) begin
                sh_data_out[j*d+i] = key_mem[act_slot][i][j];
            end
        end
    end

    assign aes_mode_256  = (slot_size[act_slot] == 2'd2);
    assign aes_mode_192  = (slot_size[act_slot] == 2'd1);
    assign busy          = (state != IDLE) || pending;
    assign data_in_ready = (state == LOAD);

endmodule

// File: tb/tb_msk_key_bank.sv
module tb_msk_key_bank;

    localparam int D = 2;
    localparam int BITS = 256;
    localparam int RR = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [31:0]          data_in = '0;
    logic                 data_in_valid = 1'b0;
    logic                 data_in_ready;
    logic                 start_load = 1'b0;
    logic [0:0]           load_slot = '0;
    logic [1:0]           key_size_cfg = '0;
    logic [0:0]           sel_slot = '0;
    logic                 sel_valid = 1'b0;
`ifdef MSK_KEY_BANK_ZEROIZE_EN
    logic                 zeroize = 1'b0;
`endif
    logic                 aes_busy = 1'b0;
    logic [(D-1)*RR-1:0]  rnd = '0;
    logic                 rnd_valid = 1'b0;
    logic [D*BITS-1:0]    sh_data_out;
    logic                 aes_mode_256, aes_mode_192, busy;

    msk_key_bank dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .start_load(start_load), .load_slot(load_slot), .key_size_cfg(key_size_cfg),
        .sel_slot(sel_slot), .sel_valid(sel_valid),
`ifdef MSK_KEY_BANK_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .aes_busy(aes_busy), .rnd_rfrsh_in(rnd), .rnd_rfrsh_in_valid(rnd_valid),
        .sh_data_out(sh_data_out), .aes_mode_256(aes_mode_256),
        .aes_mode_192(aes_mode_192), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {K_SH, K_BUSY, K_RDY, K_M256, K_M192, K_UNSH, K_UPPER} kind_t;
    typedef struct {
        string        name;
        kind_t        kind;
        logic [511:0] exp;
    } item_t;

    item_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: shares per slot, slot sizes, active slot.
    logic [255:0] m_sh [2][2];
    int           m_size [2];
    int           m_act;

    function automatic logic [255:0] share_of(input logic [511:0] bus, input int i);
        logic [255:0] r;
        for (int j = 0; j < 256; j++) r[j] = bus[j*2+i];
        return r;
    endfunction

    function automatic logic [511:0] model_bus();
        logic [511:0] b;
        for (int j = 0; j < 256; j++) begin
            b[j*2]   = m_sh[m_act][0][j];
            b[j*2+1] = m_sh[m_act][1][j];
        end
        return b;
    endfunction

    function automatic logic [31:0] word(input int seed, input int s, input int w);
        return {8'(seed + 64), 8'(s*16 + w), 16'(16'hC3A5 ^ (w*16'h0457) ^ (s*16'h1B00))};
    endfunction

    function automatic logic [15:0] rval(input int k);
        return 16'(16'h9E37 ^ ((k+1)*16'h0B1D));
    endfunction

    // Monitor: every pending expectation is compared against the DUT on the
    // falling edge, away from the active clock edge.
    item_t        mon_it;
    logic [511:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_it = sb.pop_front();
            case (mon_it.kind)
                K_SH:    mon_act = sh_data_out;
                K_BUSY:  mon_act = 512'(busy);
                K_RDY:   mon_act = 512'(data_in_ready);
                K_M256:  mon_act = 512'(aes_mode_256);
                K_M192:  mon_act = 512'(aes_mode_192);
                K_UNSH:  mon_act = {256'b0, share_of(sh_data_out, 0) ^ share_of(sh_data_out, 1)};
                default: mon_act = {256'b0, sh_data_out[511:256]};
            endcase
            n_chk++;
            if (mon_act !== mon_it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", mon_it.name, mon_act, mon_it.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input kind_t k, input logic [511:0] e);
        item_t it;
        it.name = n;
        it.kind = k;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic check_all(input string tag);
        expect_v({tag, "_sh"},   K_SH,   model_bus());
        expect_v({tag, "_m256"}, K_M256, 512'(m_size[m_act] == 256));
        expect_v({tag, "_m192"}, K_M192, 512'(m_size[m_act] == 192));
    endtask

    task automatic model_clear_all();
        for (int s = 0; s < 2; s++) begin
            m_sh[s][0] = '0;
            m_sh[s][1] = '0;
            m_size[s]  = 128;
        end
    endtask

    task automatic sel(input int s);
        sel_slot  = 1'(s);
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        m_act     = s;
    endtask

    // Loads a key; stall_at inserts one idle cycle before that beat,
    // rise_at raises aes_busy with that beat, stop_after cuts the load short.
    task automatic load_key(input int slot, input int cfg, input int seed,
                            input int stall_at, input int rise_at, input int stop_after);
        int nw;
        start_load   = 1'b1;
        load_slot    = 1'(slot);
        key_size_cfg = 2'(cfg);
        tick();
        start_load   = 1'b0;
        m_sh[slot][0] = '0;
        m_sh[slot][1] = '0;
        m_size[slot]  = (cfg == 2) ? 256 : (cfg == 1) ? 192 : 128;
        nw = m_size[slot] / 32;
        for (int b = 0; b < 2*nw; b++) begin
            if (b == stop_after) break;
            if (b == stall_at) begin
                data_in_valid = 1'b0;
                data_in       = 32'hDEADBEEF;
                tick();
                expect_v("stall_ready", K_RDY, 512'(1));
            end
            if (b == rise_at) aes_busy = 1'b1;
            data_in       = word(seed, b / nw, b % nw);
            data_in_valid = 1'b1;
            tick();
            m_sh[slot][b / nw][(b % nw)*32 +: 32] = data_in;
        end
        data_in_valid = 1'b0;
    endtask

    task automatic rstep(input int k, input bit v, input int rs);
        rnd       = rval(rs);
        rnd_valid = v;
        tick();
        rnd_valid = 1'b0;
        if (v) begin
            m_sh[m_act][1][k*16 +: 16] = m_sh[m_act][1][k*16 +: 16] ^ rnd;
            m_sh[m_act][0][k*16 +: 16] = m_sh[m_act][0][k*16 +: 16] ^ rnd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] key192;
        model_clear_all();
        m_act = 0;

        // Reset state
        tick();
        tick();
        check_all("reset");
        expect_v("reset_busy", K_BUSY, 512'(0));
        expect_v("reset_ready", K_RDY, 512'(0));
        rst = 1'b1;
        tick();
        tick();

        // 256-bit load into slot 1 with a stall in the middle
        load_key(1, 2, 1, 4, -1, -1);
        expect_v("load256_busy_drop", K_BUSY, 512'(0));
        expect_v("load256_ready_drop", K_RDY, 512'(0));
        check_all("load256_inactive");
        sel(1);
        check_all("load256_active");
        expect_v("load256_unshared", K_UNSH, {256'b0, m_sh[1][0] ^ m_sh[1][1]});

        // 128-bit load over the active 256-bit slot; visible as beats land
        start_load   = 1'b1;
        load_slot    = 1'b1;
        key_size_cfg = 2'd0;
        tick();
        start_load   = 1'b0;
        m_sh[1][0] = '0;
        m_sh[1][1] = '0;
        m_size[1]  = 128;
        check_all("load128_cleared");
        expect_v("load128_busy", K_BUSY, 512'(1));
        for (int b = 0; b < 8; b++) begin
            data_in       = word(2, b / 4, b % 4);
            data_in_valid = 1'b1;
            tick();
            m_sh[1][b / 4][(b % 4)*32 +: 32] = data_in;
            if (b == 0) check_all("load128_beat0");
        end
        data_in_valid = 1'b0;
        check_all("load128_done");
        expect_v("load128_upper_zero", K_UPPER, 512'(0));
        expect_v("load128_busy_drop", K_BUSY, 512'(0));

        // 192-bit refresh with randomness every other cycle
        load_key(0, 1, 3, -1, -1, -1);
        sel(0);
        check_all("ref192_pre");
        key192 = m_sh[0][0] ^ m_sh[0][1];
        aes_busy = 1'b1;
        tick();
        expect_v("ref192_busy", K_BUSY, 512'(1));
        for (int c = 0; c < 24; c++) begin
            rstep(c / 2, (c % 2) == 0, c / 2);
            if (c == 11) expect_v("ref192_busy_mid", K_BUSY, 512'(1));
        end
        expect_v("ref192_busy_drop", K_BUSY, 512'(0));
        check_all("ref192_post");
        expect_v("ref192_unshared", K_UNSH, {256'b0, key192});
        aes_busy = 1'b0;
        tick();

        // aes_busy rise during LOAD: load completes, refresh follows,
        // start_load during REFRESH is ignored
        load_key(1, 0, 4, -1, 3, -1);
        expect_v("pend_busy_idle", K_BUSY, 512'(1));
        expect_v("pend_ready_idle", K_RDY, 512'(0));
        tick();
        expect_v("pend_busy_refresh", K_BUSY, 512'(1));
        start_load   = 1'b1;
        load_slot    = 1'b0;
        key_size_cfg = 2'd2;
        for (int k = 0; k < 12; k++) rstep(k, 1'b1, k + 20);
        start_load = 1'b0;
        expect_v("pend_busy_drop", K_BUSY, 512'(0));
        check_all("pend_post");
        expect_v("pend_unshared", K_UNSH, {256'b0, key192});
        aes_busy = 1'b0;
        tick();
        sel(1);
        check_all("pend_slot1");
        expect_v("pend_slot1_unshared", K_UNSH, {256'b0, m_sh[1][0] ^ m_sh[1][1]});

        // Reset in the middle of a load into the active slot
        load_key(1, 2, 5, -1, -1, 5);
        check_all("rstmid_partial");
        @(negedge clk);
        #1;
        rst = 1'b0;
        aes_busy = 1'b1;
        #1;
        model_clear_all();
        m_act = 0;
        check_all("rstmid_zero");
        expect_v("rstmid_busy", K_BUSY, 512'(0));
        expect_v("rstmid_ready", K_RDY, 512'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        expect_v("rel_no_refresh_busy", K_BUSY, 512'(0));
        aes_busy = 1'b0;
        tick();
        load_key(1, 0, 6, -1, -1, -1);
        expect_v("reload_busy", K_BUSY, 512'(0));
        check_all("reload_inactive");
        sel(1);
        check_all("reload_active");
        expect_v("reload_unshared", K_UNSH, {256'b0, m_sh[1][0] ^ m_sh[1][1]});

`ifdef MSK_KEY_BANK_ZEROIZE_EN
        // Zeroize with a refresh pending
        load_key(1, 0, 7, -1, 2, -1);
        expect_v("zero_pending_busy", K_BUSY, 512'(1));
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        model_clear_all();
        check_all("zero_cleared");
        expect_v("zero_state_busy", K_BUSY, 512'(1));
        tick();
        expect_v("zero_idle_busy", K_BUSY, 512'(0));
        aes_busy = 1'b0;
        for (int k = 0; k < 4; k++) rstep(k, 1'b0, k + 40);
        rnd = rval(50);
        rnd_valid = 1'b1;
        tick();
        tick();
        rnd_valid = 1'b0;
        check_all("zero_no_refresh");
        expect_v("zero_no_refresh_busy", K_BUSY, 512'(0));
        sel(0);
        check_all("zero_slot0");
`endif

        tick();
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
